// File: rtl/auth_pkg.sv
// Shared definitions for the certificate-chain retrieval path: controller state
// encodings, error codes and the standard certificate size limits.
package auth_pkg;

    typedef enum logic [4:0] {
        ST_IDLE     = 5'b00001,
        ST_REQUEST  = 5'b00010,
        ST_WAIT_RSP = 5'b00100,
        ST_DONE     = 5'b01000,
        ST_ERROR    = 5'b10000
    } auth_state_t;

    localparam logic [1:0] AUTH_ERR_RSP     = 2'd0;
    localparam logic [1:0] AUTH_ERR_TIMEOUT = 2'd1;
    localparam logic [1:0] AUTH_ERR_PROTO   = 2'd2;
    localparam logic [1:0] AUTH_ERR_SIZE    = 2'd3;

    localparam int MaxLeafCertSize         = 640;
    localparam int MaxIntermediateCertSize = 512;
    localparam int MaxACDSize              = 128;
    localparam int MaxCertChainSize        = 4096;

    function automatic logic [15:0] min_len(input logic [15:0] a, input logic [15:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/auth_timeout_timer.sv
// Per-request response timer: counts while enabled and flags the last cycle of
// the window so the sequencer can retry or give up.
module auth_timeout_timer #(
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] count;

    assign expired = enable && (count == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= expired ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/auth_cert_chain_sequencer.sv
// Sequences chunked GET_CERTIFICATE reads of one certificate chain, tracking
// offset/remainder from each response with per-request timeout and retries.
module auth_cert_chain_sequencer
    import auth_pkg::*;
#(
    parameter int CHUNK_SIZE     = 256,
    parameter int MAX_CHAIN_SIZE = 4096,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int MAX_RETRIES    = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  slot,
    input  logic        abort,
    output logic        req_valid,
    input  logic        req_ready,
    output logic [2:0]  req_slot,
    output logic [15:0] req_offset,
    output logic [15:0] req_length,
    input  logic        rsp_valid,
    input  logic [15:0] rsp_portion,
    input  logic [15:0] rsp_remainder,
    input  logic        rsp_error,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [1:0]  err_code,
    output logic [15:0] bytes_read
);

    if (MAX_CHAIN_SIZE < 1 || MAX_CHAIN_SIZE > 65535) begin : g_bad_max_chain
        $error("MAX_CHAIN_SIZE must be in 1..65535");
    end
    if (CHUNK_SIZE < 1 || CHUNK_SIZE > MAX_CHAIN_SIZE) begin : g_bad_chunk
        $error("CHUNK_SIZE must be in 1..MAX_CHAIN_SIZE");
    end

    localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
    localparam logic [15:0] CHUNK_LEN = 16'(CHUNK_SIZE);
    localparam logic [15:0] FIRST_LEN = min_len(CHUNK_LEN, 16'(MAX_CHAIN_SIZE));
    localparam logic [17:0] MAX_TOTAL = 18'(MAX_CHAIN_SIZE);
    localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRIES);

    auth_state_t   state_reg;
    logic [2:0]    slot_reg;
    logic [15:0]   offset_reg;
    logic [15:0]   length_reg;
    logic [RW-1:0] retry_reg;

    logic        expired;
    logic [17:0] claimed_total;
    logic        proto_bad;
    logic        size_bad;
    logic [15:0] new_offset;
    logic [15:0] next_len;

    auth_timeout_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (state_reg != ST_WAIT_RSP),
        .enable (state_reg == ST_WAIT_RSP),
        .expired(expired)
    );

    // Widened so a hostile portion+remainder cannot wrap past the size check.
    assign claimed_total = {2'b00, offset_reg} + {2'b00, rsp_portion} + {2'b00, rsp_remainder};
    assign size_bad      = claimed_total > MAX_TOTAL;
    assign proto_bad     = (rsp_portion > length_reg) ||
                           ((rsp_portion == 16'd0) && (rsp_remainder != 16'd0));
    assign new_offset    = offset_reg + rsp_portion;
    assign next_len      = min_len(CHUNK_LEN, rsp_remainder);

    assign req_slot   = slot_reg;
    assign req_offset = offset_reg;
    assign req_length = length_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= ST_IDLE;
            slot_reg   <= '0;
            offset_reg <= '0;
            length_reg <= '0;
            retry_reg  <= '0;
            req_valid  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            err_code   <= '0;
            bytes_read <= '0;
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            if (abort) begin
                state_reg <= ST_IDLE;
                req_valid <= 1'b0;
                busy      <= 1'b0;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        if (start) begin
                            slot_reg   <= slot;
                            offset_reg <= '0;
                            length_reg <= FIRST_LEN;
                            retry_reg  <= '0;
                            err_code   <= '0;
                            bytes_read <= '0;
                            state_reg  <= ST_REQUEST;
                            req_valid  <= 1'b1;
                            busy       <= 1'b1;
                        end
                    end
                    ST_REQUEST: begin
                        if (req_ready) begin
                            state_reg <= ST_WAIT_RSP;
                            req_valid <= 1'b0;
                        end
                    end
                    ST_WAIT_RSP: begin
                        if (rsp_valid) begin
                            if (rsp_error || proto_bad || size_bad) begin
                                state_reg <= ST_ERROR;
                                error     <= 1'b1;
                                err_code  <= rsp_error ? AUTH_ERR_RSP :
                                             proto_bad ? AUTH_ERR_PROTO : AUTH_ERR_SIZE;
                            end else begin
                                offset_reg <= new_offset;
                                bytes_read <= new_offset;
                                retry_reg  <= '0;
                                if (rsp_remainder == 16'd0) begin
                                    state_reg <= ST_DONE;
                                    done      <= 1'b1;
                                end else begin
                                    length_reg <= next_len;
                                    state_reg  <= ST_REQUEST;
                                    req_valid  <= 1'b1;
                                end
                            end
                        end else if (expired) begin
                            if (retry_reg < RETRY_LIMIT) begin
                                retry_reg <= retry_reg + 1'b1;
                                state_reg <= ST_REQUEST;
                                req_valid <= 1'b1;
                            end else begin
                                state_reg <= ST_ERROR;
                                error     <= 1'b1;
                                err_code  <= AUTH_ERR_TIMEOUT;
                            end
                        end
                    end
                    ST_DONE, ST_ERROR: begin
                        state_reg <= ST_IDLE;
                        busy      <= 1'b0;
                    end
                    default: begin
                        state_reg <= ST_IDLE;
                        req_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
